// File: rtl/sample_pos_pkg.sv
// sample_pos_pkg: shared definitions for the harmonic sample-position scheduler.
//   - FSM state encoding (CLEAR / IDLE / ACCESS / OUT) and its enum type
//   - NYQUIST_THRESH: accumulated increment at/above which a frame stops early
//   - CLEAR_LAST: last RAM address written by the post-reset clear sweep
// NYQUIST_THRESH and CLEAR_LAST describe the default 8-bit address / 16-bit data build.
package sample_pos_pkg;

  localparam logic [1:0] CLEAR  = 2'd0;
  localparam logic [1:0] IDLE   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] OUT    = 2'd3;

  typedef enum logic [1:0] {
    S_CLEAR  = CLEAR,
    S_IDLE   = IDLE,
    S_ACCESS = ACCESS,
    S_OUT    = OUT
  } state_t;

  localparam logic [16:0] NYQUIST_THRESH = 17'h08000;
  localparam logic [7:0]  CLEAR_LAST     = 8'hFF;

endpackage

// File: rtl/sample_pos_scheduler.sv
// sample_pos_scheduler: per-audio-sample sequencer for the harmonic position RAM.
// After reset it sweeps the RAM to zero, then on every accepted sample_start walks
// harmonics 0..n-1: reads the stored position, hands it to the sine stage over a
// valid/ready port and writes back position + (h+1)*freq_inc. Stops early once the
// harmonic increment reaches Nyquist.
//
// Optional feature: define HARD_SYNC_EN to add the hard_sync input. A pulse arms a
// sticky request; the next accepted frame then restarts every phase at zero.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   sample_start          frame start pulse (ignored + overrun when not idle)
//   freq_inc              fundamental phase increment (latched at start)
//   harmonic_count        harmonics per frame (latched at start, 0 = none)
//   ram_addr/din/we       RAM write side; ram_addr also drives the async read
//   ram_dout              RAM async read data
//   pos_data/harmonic     pre-increment position and its harmonic index
//   pos_valid/pos_ready   output handshake
//   busy                  high while clearing or inside a frame
//   frame_done            one-cycle pulse after the frame ends
//   overrun               same-cycle pulse for a rejected sample_start
//   hard_sync             (HARD_SYNC_EN) oscillator sync request
module sample_pos_scheduler
  import sample_pos_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef HARD_SYNC_EN
  input  logic                  hard_sync,
`endif
  input  logic                  sample_start,
  input  logic [DATA_WIDTH-1:0] freq_inc,
  input  logic [ADDR_WIDTH-1:0] harmonic_count,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] pos_data,
  output logic [ADDR_WIDTH-1:0] pos_harmonic,
  output logic                  pos_valid,
  input  logic                  pos_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  // Generic forms of the package constants; identical at the default widths.
  localparam logic [ADDR_WIDTH-1:0] H_LAST = '1;
  localparam logic [DATA_WIDTH:0]   NYQ    = {2'b01, {(DATA_WIDTH-1){1'b0}}};

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   h;
  logic [ADDR_WIDTH-1:0]   n;
  logic [DATA_WIDTH-1:0]   inc;
  logic [DATA_WIDTH:0]     acc;   // (h+1)*inc; one spare bit so the Nyquist test can't alias
  logic                    sync_on;

  logic busy_st, start_ok, at_nyq, last_h;

  assign busy_st = (state != S_IDLE);
  // The frame_done cycle still counts as the tail of the previous frame.
  assign start_ok = sample_start && (state == S_IDLE) && !frame_done;
  assign at_nyq   = (acc >= NYQ);
  assign last_h   = (({1'b0, h} + (ADDR_WIDTH+1)'(1)) == {1'b0, n});

  // Write port and status are decoded from registered state; reset forces them
  // low so an aborted frame cannot write in the reset cycle.
  assign ram_addr = reset ? '0 : h;
  assign ram_we   = !reset && ((state == S_CLEAR) || ((state == S_ACCESS) && !at_nyq));
  assign busy     = !reset && busy_st;
  assign overrun  = !reset && sample_start && (busy_st || frame_done);

  always_comb begin
    ram_din = '0;
    if (!reset && state == S_ACCESS)
      ram_din = sync_on ? acc[DATA_WIDTH-1:0] : ram_dout + acc[DATA_WIDTH-1:0];
  end

`ifdef HARD_SYNC_EN
  logic sync_pend;
  logic sync_flag;

  // A sync pulse landing on the consuming start re-arms the request for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pend <= 1'b0;
      sync_flag <= 1'b0;
    end else if (start_ok) begin
      sync_flag <= sync_pend;
      sync_pend <= hard_sync;
    end else if (hard_sync) begin
      sync_pend <= 1'b1;
    end
  end

  assign sync_on = sync_flag;
`else
  assign sync_on = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_CLEAR;
      h            <= '0;
      n            <= '0;
      inc          <= '0;
      acc          <= '0;
      pos_data     <= '0;
      pos_harmonic <= '0;
      pos_valid    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_CLEAR: begin
          h <= h + 1'b1;  // wraps to 0 on the last address
          if (h == H_LAST) state <= S_IDLE;
        end
        S_IDLE: begin
          if (start_ok) begin
            inc <= freq_inc;
            n   <= harmonic_count;
            acc <= {1'b0, freq_inc};
            h   <= '0;
            if (harmonic_count == '0) frame_done <= 1'b1;
            else                      state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (at_nyq) begin
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end else begin
            pos_data     <= sync_on ? '0 : ram_dout;
            pos_harmonic <= h;
            pos_valid    <= 1'b1;
            state        <= S_OUT;
          end
        end
        S_OUT: begin
          // pos_valid is always set here, so pos_ready alone completes the handshake.
          if (pos_ready) begin
            pos_valid <= 1'b0;
            h         <= h + 1'b1;
            acc       <= acc + {1'b0, inc};
            if (last_h) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_pos_scheduler.sv
// tb_sample_pos_scheduler: drives the scheduler against a behavioural RAM and
// checks it against a frame-level model (expected emitted positions and RAM image).
module tb_sample_pos_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_start = 1'b0;
  logic [15:0] freq_inc = '0;
  logic [7:0]  harmonic_count = '0;
  logic        pos_ready = 1'b0;
  logic [7:0]  ram_addr, pos_harmonic;
  logic [15:0] ram_din, ram_dout, pos_data;
  logic        ram_we, pos_valid, busy, frame_done, overrun;
`ifdef HARD_SYNC_EN
  logic        hard_sync = 1'b0;
`endif

  logic [15:0] ram     [256];
  logic [15:0] mem_exp [256];
  int          vectors = 0;
  int          miscompares = 0;
  bit          sync_pend_m = 1'b0;

  always #5 clk = ~clk;

  assign ram_dout = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;

  sample_pos_scheduler dut (
    .clk            (clk),
    .reset          (reset),
`ifdef HARD_SYNC_EN
    .hard_sync      (hard_sync),
`endif
    .sample_start   (sample_start),
    .freq_inc       (freq_inc),
    .harmonic_count (harmonic_count),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_we         (ram_we),
    .ram_dout       (ram_dout),
    .pos_data       (pos_data),
    .pos_harmonic   (pos_harmonic),
    .pos_valid      (pos_valid),
    .pos_ready      (pos_ready),
    .busy           (busy),
    .frame_done     (frame_done),
    .overrun        (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One frame: model computes the expected output stream and the RAM image it leaves.
  task automatic run_frame(input logic [15:0] inc, input logic [7:0] n,
                           input int stall_pct, input bit poke);
    logic [15:0] exp_d[$];
    logic [7:0]  exp_h[$];
    int unsigned a;
    bit          use_sync, done, held;
    logic [15:0] hd;
    logic [7:0]  hh;
    int          got, errs, nbad;
    use_sync = sync_pend_m;
    sync_pend_m = 1'b0;
    done = 0; held = 0; got = 0; errs = 0; nbad = 0; hd = '0; hh = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = (i + 1) * int'(inc);
      if (a >= 32'h8000) break;
      exp_h.push_back(8'(i));
      exp_d.push_back(use_sync ? 16'h0 : mem_exp[i]);
      mem_exp[i] = use_sync ? a[15:0] : mem_exp[i] + a[15:0];
    end

    @(negedge clk);
    chk("idle_busy", busy, 0);
    sample_start = 1'b1; freq_inc = inc; harmonic_count = n;
    #1 chk("start_no_overrun", overrun, 0);
    @(negedge clk);
    sample_start = 1'b0;
    freq_inc = 16'($urandom);        // must not affect the running frame
    harmonic_count = 8'($urandom);
    for (int c = 0; c < 3000 && !done; c++) begin
      sample_start = 1'b0;
      pos_ready = ($urandom_range(0, 99) >= stall_pct);
      #1;
      if (held && (!pos_valid || pos_data !== hd || pos_harmonic !== hh || ram_we)) errs++;
      if (poke && c == 1 && exp_d.size() >= 2) begin
        sample_start = 1'b1;
        #1 chk("overrun_mid", overrun, 1);
      end
      if (pos_valid && pos_ready) begin
        if (got < exp_d.size()) begin
          chk("pos_harmonic", pos_harmonic, exp_h[got]);
          chk("pos_data", pos_data, exp_d[got]);
        end
        got++;
      end
      held = pos_valid && !pos_ready;
      hd = pos_data; hh = pos_harmonic;
      if (frame_done) done = 1;
      @(negedge clk);
    end
    sample_start = 1'b0;
    chk("frame_done_seen", done, 1);
    chk("pos_count", got, exp_d.size());
    chk("hold_stable", errs, 0);
    for (int i = 0; i < 256; i++) if (ram[i] !== mem_exp[i]) nbad++;
    chk("ram_image", nbad, 0);
  endtask

  initial begin
    int wc, bc, bad;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'($urandom);
      mem_exp[i] = '0;
    end

    // reset
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", ram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", pos_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_addr", ram_addr, 0);

    // clear sweep
    @(negedge clk);
    reset = 1'b0;
    wc = 0; bc = 0; bad = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (c == 100) begin
        sample_start = 1'b1;
        #1 chk("overrun_clear", overrun, 1);
      end
      if (ram_we) begin
        if (ram_addr !== 8'(wc) || ram_din !== 16'h0) bad++;
        wc++;
      end
      if (!busy) break;
      bc++;
      @(negedge clk);
      sample_start = 1'b0;
    end
    sample_start = 1'b0;
    chk("clear_writes", wc, 256);
    chk("clear_busy_cycles", bc, 256);
    chk("clear_addr_din", bad, 0);

    // directed frames
    run_frame(16'h0100, 8'd4, 0, 0);
    run_frame(16'h0100, 8'd4, 0, 0);
    chk("ram0", ram[0], 16'h0200);
    chk("ram1", ram[1], 16'h0400);
    chk("ram2", ram[2], 16'h0600);
    chk("ram3", ram[3], 16'h0800);
    run_frame(16'h3000, 8'd8, 0, 1);   // Nyquist cut after two harmonics
    run_frame(16'h0123, 8'd6, 70, 1);  // heavy back-pressure
    run_frame(16'h0100, 8'd0, 0, 0);   // empty frame
    run_frame(16'h7FFF, 8'd3, 0, 0);   // only harmonic 0 below Nyquist
    run_frame(16'h8000, 8'd3, 0, 0);   // fundamental at Nyquist: nothing emitted

`ifdef HARD_SYNC_EN
    @(negedge clk);
    hard_sync = 1'b1;
    @(negedge clk);
    hard_sync = 1'b0;
    sync_pend_m = 1'b1;
    run_frame(16'h0100, 8'd2, 0, 0);
    run_frame(16'h0100, 8'd2, 0, 0);
`endif

    // randomized frames
    for (int f = 0; f < 12; f++)
      run_frame(16'($urandom_range(0, 16'h1800)), 8'($urandom_range(0, 40)),
                $urandom_range(0, 50), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
